// File: rtl/bp_update_scheduler_pkg.sv
// Shared definitions for the branch-predictor update scheduler: FSM state
// encodings, queue-entry layout and a packing helper.
package bp_update_scheduler_pkg;

  // Predictor-clear sweep in progress, or normal queue operation.
  typedef enum logic {
    BpsSweep = 1'b0,
    BpsRun   = 1'b1
  } bps_state_e;

  // Queue entry: pc(32) + tgt(32) + taken(1) + btb(1).
  localparam int unsigned BP_UPD_W = 66;

  // Bit ranges of each field inside a flat entry.
  localparam int unsigned BP_UPD_PC_MSB  = 65;
  localparam int unsigned BP_UPD_PC_LSB  = 34;
  localparam int unsigned BP_UPD_TGT_MSB = 33;
  localparam int unsigned BP_UPD_TGT_LSB = 2;
  localparam int unsigned BP_UPD_TAKEN   = 1;
  localparam int unsigned BP_UPD_BTB     = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        taken;
    logic        btb;
  } bp_upd_t;

  function automatic logic [BP_UPD_W-1:0] bp_upd_pack(input logic [31:0] pc,
                                                       input logic [31:0] tgt,
                                                       input logic        taken,
                                                       input logic        btb);
    bp_upd_t e;
    e.pc    = pc;
    e.tgt   = tgt;
    e.taken = taken;
    e.btb   = btb;
    return e;
  endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Two-write / one-read update queue. When both write ports fire in a cycle,
// port 0 lands at the write pointer and port 1 right after it; a lone write
// (from either port) lands at the write pointer. clear_i empties the queue
// and wins over any concurrent enqueue/dequeue.
module bp_update_fifo
  import bp_update_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     clear_i,
  input  logic                     wr0_en_i,
  input  logic [BP_UPD_W-1:0]      wr0_data_i,
  input  logic                     wr1_en_i,
  input  logic [BP_UPD_W-1:0]      wr1_data_i,
  input  logic                     rd_en_i,
  output logic [BP_UPD_W-1:0]      rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_count;
  logic [BP_UPD_W-1:0] r_mem [DEPTH];

  logic                w_wr_a_en;
  logic [BP_UPD_W-1:0] w_wr_a_data;
  logic                w_wr_b_en;
  logic [PW-1:0]       w_wr_ptr_p1;
  logic [1:0]          w_nenq;
  logic [PW-1:0]       w_wr_ptr_d;
  logic [PW-1:0]       w_rd_ptr_d;
  logic [PW:0]         w_count_d;

  assign w_wr_a_en   = wr0_en_i | wr1_en_i;
  assign w_wr_a_data = wr0_en_i ? wr0_data_i : wr1_data_i;
  assign w_wr_b_en   = wr0_en_i & wr1_en_i;
  assign w_wr_ptr_p1 = r_wr_ptr + PW'(1);
  assign w_nenq      = {1'b0, wr0_en_i} + {1'b0, wr1_en_i};

  // Next pointer/count values; pointers wrap naturally since DEPTH is 2**PW.
  always_comb begin
    w_wr_ptr_d = r_wr_ptr + PW'(w_nenq);
    w_rd_ptr_d = r_rd_ptr + PW'(rd_en_i);
    w_count_d  = r_count + (PW+1)'(w_nenq) - (PW+1)'(rd_en_i);
    if (clear_i) begin
      w_wr_ptr_d = '0;
      w_rd_ptr_d = '0;
      w_count_d  = '0;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_d;
      r_rd_ptr <= w_rd_ptr_d;
      r_count  <= w_count_d;
    end
  end

  // Entry storage; reset so the head fields read as zero out of reset.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (!clear_i) begin
      if (w_wr_a_en) r_mem[r_wr_ptr]    <= w_wr_a_data;
      if (w_wr_b_en) r_mem[w_wr_ptr_p1] <= wr1_data_i;
    end
  end

  assign rd_data_o = r_mem[r_rd_ptr];
  assign count_o   = r_count;

endmodule

// File: rtl/bp_update_scheduler.sv
// Sequences branch-predictor writes: two execute lanes feed an update queue
// that drains one entry per cycle while the predictor write window is open.
// After reset or flush a sweep walks every table index to clear it.
// Optional macro BP_UPD_COALESCE_EN: when both lanes resolve the same PC in
// one cycle, only the younger lane (lane1) is enqueued.
module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int unsigned ABITS = 10,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             pc_we_i,
  input  logic             l0_valid_i,
  input  logic [31:0]      l0_pc_i,
  input  logic [31:0]      l0_tgt_i,
  input  logic             l0_taken_i,
  input  logic             l0_btb_i,
  input  logic             l1_valid_i,
  input  logic [31:0]      l1_pc_i,
  input  logic [31:0]      l1_tgt_i,
  input  logic             l1_taken_i,
  input  logic             l1_btb_i,
  output logic             stall_o,
  output logic             upd_valid_o,
  output logic [31:0]      upd_pc_o,
  output logic [31:0]      upd_tgt_o,
  output logic             upd_taken_o,
  output logic             upd_btb_o,
  output logic             sweep_we_o,
  output logic [ABITS-1:0] sweep_idx_o,
  output logic             busy_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  bps_state_e          r_state;
  bps_state_e          w_state_d;
  logic [ABITS-1:0]    r_idx;
  logic [ABITS-1:0]    w_idx_d;

  logic                w_sweep;
  logic [CW-1:0]       w_count;
  logic [CW-1:0]       w_free;
  logic                w_stall;
  logic                w_enq_ok;
  logic                w_coalesce;
  logic                w_l0_en;
  logic                w_l1_en;
  logic                w_upd_valid;
  logic                w_deq;
  logic [BP_UPD_W-1:0] w_l0_data;
  logic [BP_UPD_W-1:0] w_l1_data;
  logic [BP_UPD_W-1:0] w_head;

  // Sweep/run state and sweep index registers.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= BpsSweep;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_d;
      r_idx   <= w_idx_d;
    end
  end

  // Next state: sweep runs exactly 2**ABITS cycles; flush always restarts it at 0.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    unique case (r_state)
      BpsSweep: begin
        if (flush_i) begin
          w_idx_d = '0;
        end else if (r_idx == {ABITS{1'b1}}) begin
          w_state_d = BpsRun;
          w_idx_d   = '0;
        end else begin
          w_idx_d = r_idx + ABITS'(1);
        end
      end
      BpsRun: begin
        if (flush_i) begin
          w_state_d = BpsSweep;
          w_idx_d   = '0;
        end
      end
      default: begin
        w_state_d = BpsSweep;
        w_idx_d   = '0;
      end
    endcase
  end

  assign w_sweep     = (r_state == BpsSweep);
  assign sweep_we_o  = w_sweep;
  assign busy_o      = w_sweep;
  assign sweep_idx_o = r_idx;

  // Two free slots are always required so a dual-lane cycle can never overflow.
  assign w_free  = CW'(DEPTH) - w_count;
  assign w_stall = w_sweep | (w_free < CW'(2));
  assign stall_o = w_stall;

`ifdef BP_UPD_COALESCE_EN
  assign w_coalesce = l0_valid_i & l1_valid_i & (l0_pc_i == l1_pc_i);
`else
  assign w_coalesce = 1'b0;
`endif

  assign w_enq_ok = !w_stall;
  assign w_l0_en  = w_enq_ok & l0_valid_i & !w_coalesce;
  assign w_l1_en  = w_enq_ok & l1_valid_i;

  assign w_l0_data = bp_upd_pack(l0_pc_i, l0_tgt_i, l0_taken_i, l0_btb_i);
  assign w_l1_data = bp_upd_pack(l1_pc_i, l1_tgt_i, l1_taken_i, l1_btb_i);

  assign w_upd_valid = (w_count != '0) & !w_sweep;
  assign w_deq       = w_upd_valid & pc_we_i;

  bp_update_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .clear_i    (flush_i),
    .wr0_en_i   (w_l0_en),
    .wr0_data_i (w_l0_data),
    .wr1_en_i   (w_l1_en),
    .wr1_data_i (w_l1_data),
    .rd_en_i    (w_deq),
    .rd_data_o  (w_head),
    .count_o    (w_count)
  );

  assign upd_valid_o = w_upd_valid;
  assign upd_pc_o    = w_head[BP_UPD_PC_MSB:BP_UPD_PC_LSB];
  assign upd_tgt_o   = w_head[BP_UPD_TGT_MSB:BP_UPD_TGT_LSB];
  assign upd_taken_o = w_head[BP_UPD_TAKEN];
  assign upd_btb_o   = w_head[BP_UPD_BTB];

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler (ABITS=4, DEPTH=4). Lane targets are
// pc+0x40; lane0 drives taken=btb=1, lane1 taken=btb=0, unless overridden.
module tb_bp_update_scheduler;

  localparam int unsigned ABITS = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             flush = 1'b0;
  logic             pc_we = 1'b0;
  logic             l0_valid = 1'b0;
  logic [31:0]      l0_pc = '0;
  logic [31:0]      l0_tgt = '0;
  logic             l0_taken = 1'b0;
  logic             l0_btb = 1'b0;
  logic             l1_valid = 1'b0;
  logic [31:0]      l1_pc = '0;
  logic [31:0]      l1_tgt = '0;
  logic             l1_taken = 1'b0;
  logic             l1_btb = 1'b0;
  logic             stall;
  logic             upd_valid;
  logic [31:0]      upd_pc;
  logic [31:0]      upd_tgt;
  logic             upd_taken;
  logic             upd_btb;
  logic             sweep_we;
  logic [ABITS-1:0] sweep_idx;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bp_update_scheduler #(
    .ABITS (ABITS),
    .DEPTH (DEPTH)
  ) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .flush_i     (flush),
    .pc_we_i     (pc_we),
    .l0_valid_i  (l0_valid),
    .l0_pc_i     (l0_pc),
    .l0_tgt_i    (l0_tgt),
    .l0_taken_i  (l0_taken),
    .l0_btb_i    (l0_btb),
    .l1_valid_i  (l1_valid),
    .l1_pc_i     (l1_pc),
    .l1_tgt_i    (l1_tgt),
    .l1_taken_i  (l1_taken),
    .l1_btb_i    (l1_btb),
    .stall_o     (stall),
    .upd_valid_o (upd_valid),
    .upd_pc_o    (upd_pc),
    .upd_tgt_o   (upd_tgt),
    .upd_taken_o (upd_taken),
    .upd_btb_o   (upd_btb),
    .sweep_we_o  (sweep_we),
    .sweep_idx_o (sweep_idx),
    .busy_o      (busy)
  );

  typedef struct {
    logic        pc_we;
    logic        l0v;
    logic [31:0] l0pc;
    logic        l1v;
    logic [31:0] l1pc;
    logic        exp_stall;
    logic        exp_uv;
    logic [31:0] exp_pc;
    logic        exp_tk;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic v0, input logic [31:0] p0,
                       input logic v1, input logic [31:0] p1);
    pc_we    = we;
    l0_valid = v0;
    l0_pc    = p0;
    l0_tgt   = p0 + 32'h40;
    l0_taken = 1'b1;
    l0_btb   = 1'b1;
    l1_valid = v1;
    l1_pc    = p1;
    l1_tgt   = p1 + 32'h40;
    l1_taken = 1'b0;
    l1_btb   = 1'b0;
  endtask

  // Counts cycles until busy drops, bounded.
  task automatic sweep_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    int n;
    int ndeq;
    logic first_tk;
    logic last_tk;

    // test 2: single lane0 entry, one-cycle latency
    vecs[0]  = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h40,  1'b1};
    vecs[2]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
    // test 3: fill to DEPTH with the window closed, then drain in order
    vecs[3]  = '{1'b0, 1'b1, 32'h10,  1'b1, 32'h14,  1'b0, 1'b0, 32'h0,   1'b0};
    vecs[4]  = '{1'b0, 1'b1, 32'h18,  1'b1, 32'h1C,  1'b0, 1'b1, 32'h10,  1'b1};
    vecs[5]  = '{1'b0, 1'b1, 32'h50,  1'b1, 32'h54,  1'b1, 1'b1, 32'h10,  1'b1};
    vecs[6]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h10,  1'b1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 1'b1, 32'h14,  1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h18,  1'b1};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h1C,  1'b0};
    vecs[10] = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};
    // test 4: simultaneous enqueue/dequeue, pointer wrap, stall at count 3
    vecs[11] = '{1'b0, 1'b1, 32'h100, 1'b1, 32'h104, 1'b0, 1'b0, 32'h0,   1'b0};
    vecs[12] = '{1'b1, 1'b1, 32'h108, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 32'h10C, 1'b0, 32'h0,   1'b0, 1'b1, 32'h104, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h114, 1'b0, 1'b1, 32'h108, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 32'h118, 1'b0, 32'h0,   1'b1, 1'b1, 32'h10C, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h110, 1'b1};
    vecs[17] = '{1'b1, 1'b1, 32'h118, 1'b0, 32'h0,   1'b0, 1'b1, 32'h114, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b1, 32'h118, 1'b1};
    vecs[19] = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 1'b0, 32'h0,   1'b0};

    // test 1: reset values and sweep
    #2 rst = 1'b1;
    #1;
    chk("rst_sweep_we", 32'(sweep_we), 32'd1);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_upd_pc", upd_pc, 32'd0);
    chk("rst_sweep_idx", 32'(sweep_idx), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("sweep_busy", 32'(busy), 32'd1);
      chk("sweep_idx", 32'(sweep_idx), 32'(i));
      @(negedge clk);
    end
    #1;
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_sweep_we", 32'(sweep_we), 32'd0);
    chk("run_stall", 32'(stall), 32'd0);

    // tests 2-4: vector table, one row per cycle
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(vecs[i].pc_we, vecs[i].l0v, vecs[i].l0pc, vecs[i].l1v, vecs[i].l1pc);
      #1;
      chk($sformatf("v%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
      chk($sformatf("v%0d_valid", i), 32'(upd_valid), 32'(vecs[i].exp_uv));
      if (vecs[i].exp_uv) begin
        chk($sformatf("v%0d_pc", i), upd_pc, vecs[i].exp_pc);
        chk($sformatf("v%0d_tgt", i), upd_tgt, vecs[i].exp_pc + 32'h40);
        chk($sformatf("v%0d_taken", i), 32'(upd_taken), 32'(vecs[i].exp_tk));
        chk($sformatf("v%0d_btb", i), 32'(upd_btb), 32'(vecs[i].exp_tk));
      end
    end

    // test 5: flush with three queued entries
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h200, 1'b1, 32'h204);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h208, 1'b0, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    flush = 1'b1;
    #1;
    chk("flush_pre_valid", 32'(upd_valid), 32'd1);
    chk("flush_pre_pc", upd_pc, 32'h200);
    @(negedge clk);
    flush = 1'b0;
    pc_we = 1'b1;
    #1;
    chk("flush_valid", 32'(upd_valid), 32'd0);
    chk("flush_idx", 32'(sweep_idx), 32'd0);
    chk("flush_busy", 32'(busy), 32'd1);
    sweep_len(n);
    chk("flush_sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_old", 32'(upd_valid), 32'd0);
      @(negedge clk);
      #1;
    end

    // flush during sweep restarts at index 0
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("resweep_idx5", 32'(sweep_idx), 32'd5);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("resweep_idx0", 32'(sweep_idx), 32'd0);
    sweep_len(n);
    chk("resweep_len", 32'(n), 32'd16);

    // test 6: same-PC pair, lane0 not-taken, lane1 taken
    @(negedge clk);
    drive(1'b0, 1'b1, 32'h20, 1'b1, 32'h20);
    l0_taken = 1'b0;
    l0_btb   = 1'b0;
    l1_taken = 1'b1;
    l1_btb   = 1'b1;
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    ndeq     = 0;
    first_tk = 1'b0;
    last_tk  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (upd_valid === 1'b1) begin
        if (ndeq == 0) first_tk = upd_taken;
        last_tk = upd_taken;
        ndeq++;
      end
      @(negedge clk);
    end
`ifdef BP_UPD_COALESCE_EN
    chk("coal_ndeq", 32'(ndeq), 32'd1);
    chk("coal_first_taken", 32'(first_tk), 32'd1);
`else
    chk("coal_ndeq", 32'(ndeq), 32'd2);
    chk("coal_first_taken", 32'(first_tk), 32'd0);
`endif
    chk("coal_last_taken", 32'(last_tk), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
